// File: rtl/sit_pkg.sv
// rtl/sit_pkg.sv - shared types and sizes for the SiT cipher stream blocks
package sit_pkg;

  localparam int BLOCK_W       = 64;
  localparam int KEY_W         = 64;
  localparam int BYTES_PER_BLK = 8;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WAIT    = 2'd1,
    EMIT    = 2'd2
  } sit_state_t;

endpackage

// File: rtl/sit_shift8.sv
// rtl/sit_shift8.sv - parallel-load register that shifts left by one byte
module sit_shift8
  import sit_pkg::*;
#(
  parameter int W = BLOCK_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_data,
  input  logic         i_shift,
  input  logic [7:0]   i_byte,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Load wins over shift so a capture is never corrupted by a stray shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_data;
    end else if (i_shift) begin
      r_q <= {r_q[W-9:0], i_byte};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sit_stream_ctrl.sv
// rtl/sit_stream_ctrl.sv - byte-serial key/data assembly and result serializer for the SiT core
module sit_stream_ctrl
  import sit_pkg::*;
#(
  parameter int CORE_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [7:0]         s_data,
  input  logic               s_is_key,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [7:0]         m_data,
  output logic [KEY_W-1:0]   core_key,
  output logic [BLOCK_W-1:0] core_in,
  input  logic [BLOCK_W-1:0] core_out,
  output logic               key_loaded,
  output logic               err,
  output logic               busy
);

  localparam logic [3:0] LAT     = 4'(CORE_LAT);
  localparam logic [2:0] LAST_BY = 3'(BYTES_PER_BLK - 1);
  // The 8th byte comes straight from s_data, so only 7 bytes need holding.
  localparam int         IN_W    = BLOCK_W - 8;

  sit_state_t         r_state;
  logic [2:0]         r_byte_cnt;
  logic               r_grp_key;
  logic [3:0]         r_wait_cnt;
  logic [KEY_W-1:0]   r_core_key;
  logic [BLOCK_W-1:0] r_core_in;
  logic               r_key_loaded;
  logic               r_err;

  logic               w_in_acc;
  logic               w_out_acc;
  logic               w_capture;
  logic [IN_W-1:0]    w_in_sr;
  logic [BLOCK_W-1:0] w_in_word;
  logic [BLOCK_W-1:0] w_out_sr;
  logic               w_unused_out;

  assign w_in_acc     = s_valid && (r_state == COLLECT);
  assign w_out_acc    = m_ready && (r_state == EMIT);
  assign w_capture    = (r_state == WAIT) && (r_wait_cnt == 4'd1);
  assign w_in_word    = {w_in_sr, s_data};
  assign w_unused_out = ^w_out_sr[BLOCK_W-9:0];

  sit_shift8 #(.W(IN_W)) u_in_sr (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (1'b0),
    .i_load_data ('0),
    .i_shift     (w_in_acc),
    .i_byte      (s_data),
    .o_q         (w_in_sr)
  );

  sit_shift8 #(.W(BLOCK_W)) u_out_sr (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_capture),
    .i_load_data (core_out),
    .i_shift     (w_out_acc),
    .i_byte      (8'h00),
    .o_q         (w_out_sr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= COLLECT;
      r_byte_cnt   <= 3'd0;
      r_grp_key    <= 1'b0;
      r_wait_cnt   <= 4'd0;
      r_core_key   <= '0;
      r_core_in    <= '0;
      r_key_loaded <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        COLLECT: begin
          if (w_in_acc) begin
            r_byte_cnt <= r_byte_cnt + 3'd1;
            if (r_byte_cnt == 3'd0) r_grp_key <= s_is_key;
            if (r_byte_cnt == LAST_BY) begin
              if (r_grp_key) begin
                r_core_key   <= w_in_word;
                r_key_loaded <= 1'b1;
              end else if (!r_key_loaded) begin
                r_err <= 1'b1;
              end else begin
                r_core_in  <= w_in_word;
                r_wait_cnt <= LAT;
                r_state    <= WAIT;
              end
            end
          end
        end
        WAIT: begin
          r_wait_cnt <= r_wait_cnt - 4'd1;
          if (r_wait_cnt == 4'd1) r_state <= EMIT;
        end
        EMIT: begin
          if (w_out_acc) begin
            r_byte_cnt <= r_byte_cnt + 3'd1;
            if (r_byte_cnt == LAST_BY) r_state <= COLLECT;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign s_ready    = (r_state == COLLECT);
  assign m_valid    = (r_state == EMIT);
  assign busy       = (r_state != COLLECT);
  assign m_data     = w_out_sr[BLOCK_W-1 -: 8];
  assign core_key   = r_core_key;
  assign core_in    = r_core_in;
  assign key_loaded = r_key_loaded;
  assign err        = r_err;

endmodule

// File: tb/tb_sit_stream_ctrl.sv
// tb/tb_sit_stream_ctrl.sv - randomized self-checking bench for sit_stream_ctrl
module tb_sit_stream_ctrl;

  localparam int CORE_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'h00;
  logic        s_is_key = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data;
  logic [63:0] core_key;
  logic [63:0] core_in;
  logic [63:0] core_out;
  logic        key_loaded;
  logic        err;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int rmode = 0;
  int k = 0;

  always #5 clk = ~clk;

  sit_stream_ctrl #(.CORE_LAT(CORE_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_is_key   (s_is_key),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .core_key   (core_key),
    .core_in    (core_in),
    .core_out   (core_out),
    .key_loaded (key_loaded),
    .err        (err),
    .busy       (busy)
  );

  // Stub core: XOR result delayed so it is only correct CORE_LAT edges after core_in changes.
  logic [63:0] w_xor;
  logic [63:0] pipe [1:15];
  assign w_xor = core_in ^ core_key;
  always_ff @(posedge clk) begin
    pipe[1] <= w_xor;
    for (int i = 2; i < 16; i++) pipe[i] <= pipe[i-1];
  end
  assign core_out = (CORE_LAT > 1) ? pipe[(CORE_LAT > 1) ? CORE_LAT - 1 : 1] : w_xor;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    k = m_valid ? k + 1 : 0;
    case (rmode)
      0: m_ready = 1'b1;
      1: m_ready = 1'($urandom_range(0, 1));
      2: m_ready = !(k >= 3 && k < 8) && (k % 2 == 0);
      default: m_ready = 1'b0;
    endcase
  end

  // Reference model: group bytes as they are accepted, predict err and output bytes.
  logic [7:0]  grp [$];
  logic [7:0]  exp_q [$];
  logic [7:0]  rx_log [$];
  logic        grp_key, mloaded, exp_err_pend;
  logic [63:0] mkey;
  int          cyc, t_last, busy_run, last_busy_len;
  logic        prev_mv, prev_mr;
  logic [7:0]  prev_md;

  always @(negedge clk) begin
    if (!rst_n) begin
      grp.delete();
      exp_q.delete();
      mloaded = 0; mkey = '0; exp_err_pend = 0;
      prev_mv = 0; prev_mr = 0; prev_md = 0;
      busy_run = 0;
    end else begin
      logic [63:0] val;
      logic [63:0] res;
      logic        err_next;
      cyc++;
      err_next = 0;
      check("err_pulse", err, exp_err_pend);
      check("half_duplex", s_ready & m_valid, 0);
      if (exp_q.size() != 0) check("s_ready_blocked", s_ready, 0);
      if (prev_mv && !prev_mr) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, prev_md);
      end
      if (m_valid && !prev_mv) check("latency", cyc - t_last, CORE_LAT + 1);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("out_byte_extra", exp_q.size(), 1);
        else begin
          check("out_byte", m_data, exp_q.pop_front());
          rx_log.push_back(m_data);
        end
      end
      if (s_valid && s_ready) begin
        if (grp.size() == 0) grp_key = s_is_key;
        grp.push_back(s_data);
        if (grp.size() == 8) begin
          val = '0;
          for (int i = 0; i < 8; i++) val = {val[55:0], grp[i]};
          grp.delete();
          if (grp_key) begin
            mkey = val; mloaded = 1;
          end else if (!mloaded) begin
            err_next = 1;
          end else begin
            res = val ^ mkey;
            for (int i = 0; i < 8; i++) exp_q.push_back(res[63-8*i -: 8]);
            t_last = cyc;
          end
        end
      end
      exp_err_pend = err_next;
      if (busy) busy_run++;
      else if (busy_run != 0) begin
        last_busy_len = busy_run;
        busy_run = 0;
      end
      prev_mv = m_valid; prev_mr = m_ready; prev_md = m_data;
    end
  end

  task automatic send_group(input bit is_key, input logic [63:0] val, input bit flip, input bit gaps);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      int  w;
      bit  ok;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      s_valid  = 1'b1;
      s_data   = val[63-8*i -: 8];
      s_is_key = (i == 0) ? is_key : (flip ? 1'($urandom_range(0, 1)) : is_key);
      ok = 0;
      for (w = 0; w < 500; w++) begin
        @(negedge clk);
        if (s_ready) begin
          ok = 1;
          break;
        end
      end
      if (!ok) check("send_timeout", ok, 1);
      @(posedge clk);
      #1;
      s_valid  = 1'b0;
      s_data   = 8'($urandom);
      s_is_key = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        done = 1;
        break;
      end
    end
    if (!done) check("drain_timeout", done, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  exp2 [8];
    logic [63:0] kprev;
    exp2 = '{8'h01, 8'h22, 8'h47, 8'h64, 8'h8D, 8'hAE, 8'hCB, 8'hE8};

    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_core_key", core_key, 0);
    check("rst_core_in", core_in, 0);
    check("rst_key_loaded", key_loaded, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rmode = 0;

    send_group(0, 64'h1122334455667788, 0, 0);
    repeat (3) @(negedge clk);
    check("nokey_s_ready", s_ready, 1);
    check("nokey_loaded", key_loaded, 0);
    check("nokey_core_in", core_in, 0);

    send_group(1, 64'h0123456789ABCDEF, 0, 0);
    check("key_value", core_key, 64'h0123456789ABCDEF);
    check("key_loaded", key_loaded, 1);
    rx_log.delete();
    send_group(0, 64'h0001020304050607, 0, 0);
    drain();
    check("vec_len", rx_log.size(), 8);
    for (int i = 0; i < 8 && i < rx_log.size(); i++) check("vec_byte", rx_log[i], exp2[i]);

    kprev = core_key;
    send_group(0, 64'hDEADBEEFCAFEF00D, 1, 1);
    check("flip_key_kept", core_key, kprev);
    drain();

    rmode = 2;
    send_group(0, 64'h8877665544332211, 0, 0);
    drain();

    rmode = 0;
    send_group(0, 64'h0F0E0D0C0B0A0908, 0, 0);
    drain();
    check("busy_len_a", last_busy_len, CORE_LAT + 8);
    send_group(1, 64'hA5A55A5A3C3CC3C3, 0, 0);
    check("reload_key", core_key, 64'hA5A55A5A3C3CC3C3);
    send_group(0, 64'h0011223344556677, 0, 0);
    drain();
    check("busy_len_b", last_busy_len, CORE_LAT + 8);

    rmode = 1;
    for (int g = 0; g < 24; g++) begin
      send_group($urandom_range(0, 3) == 0, {32'($urandom), 32'($urandom)},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();

    rmode = 3;
    send_group(0, 64'h13579BDF02468ACE, 0, 0);
    for (int i = 0; i < 100 && !m_valid; i++) @(negedge clk);
    check("pre_rst_m_valid", m_valid, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_s_ready", s_ready, 1);
    check("arst_m_valid", m_valid, 0);
    check("arst_m_data", m_data, 0);
    check("arst_core_key", core_key, 0);
    check("arst_core_in", core_in, 0);
    check("arst_key_loaded", key_loaded, 0);
    check("arst_err", err, 0);
    check("arst_busy", busy, 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rmode = 0;
    @(negedge clk);
    check("post_rst_s_ready", s_ready, 1);

    send_group(0, 64'h2222222222222222, 0, 1);
    drain();
    check("post_rst_loaded", key_loaded, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
